// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap sequencer and trap CSR file
//
// Arbitrates exceptions, MRET and the three standard interrupts.
// Owns MSTATUS, MIE, MIP, MTVEC, MSCRATCH, MEPC, MCAUSE and MTVAL.
// Every take runs the fixed sequence IDLE -> FLUSH -> COMMIT -> REDIRECT.
//
// Ports:
//   clock, reset                 core clock, synchronous active-high reset
//   exceptionValid/Cause/Pc/Tval synchronous exception report from the pipeline
//   mretValid                    MRET at commit
//   retireValid, nextPc          instruction boundary (interrupt window) and its successor PC
//   irqSoftware/Timer/External   level interrupt sources (MIP bits 3/7/11)
//   csrAddress/WriteEnable/WriteData  forwarded CSR access (write data already RMW-resolved)
//   csrReadData, csrHit          combinational read data and address ownership
//   busy                         sequencer not in IDLE
//   flush                        kill all in-flight instructions (one cycle)
//   redirectValid, redirectPc    fetch redirect (one cycle)
//
// Optional build macro: TRAP_VECTORED_EN
//   defined   - MTVEC[0] writable; interrupts with MTVEC[0]=1 go to base + 4*code
//   undefined - MTVEC[1:0] hardwired 00; every trap goes to base
module trap_controller #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            exceptionValid,
    input  logic [3:0]      exceptionCause,
    input  logic [XLEN-1:0] exceptionPc,
    input  logic [XLEN-1:0] exceptionTval,
    input  logic            mretValid,
    input  logic            retireValid,
    input  logic [XLEN-1:0] nextPc,
    input  logic            irqSoftware,
    input  logic            irqTimer,
    input  logic            irqExternal,
    input  logic [11:0]     csrAddress,
    input  logic            csrWriteEnable,
    input  logic [XLEN-1:0] csrWriteData,
    output logic [XLEN-1:0] csrReadData,
    output logic            csrHit,
    output logic            busy,
    output logic            flush,
    output logic            redirectValid,
    output logic [XLEN-1:0] redirectPc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] EPC_MASK = ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
`else
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_COMMIT,
        ST_REDIRECT
    } state_t;

    state_t state;

    // Architectural trap CSRs
    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mip_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;

    // Trap fields captured at the take, written to the CSRs in COMMIT
    logic            pend_mret;
    logic            pend_intr;
    logic [3:0]      pend_code;
    logic [XLEN-1:0] pend_epc;
    logic [XLEN-1:0] pend_tval;

    logic [XLEN-1:0] irq_word;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] trap_target;
    logic            pend_ext;
    logic            pend_sw;
    logic            pend_tmr;
    logic            any_irq;
    logic [3:0]      irq_code;

    assign irq_word = XLEN'({irqExternal, 3'b000, irqTimer, 3'b000, irqSoftware, 3'b000});

    // An interrupt is only eligible at an instruction boundary with the global enable set.
    assign pend_ext = mstatus_mie & retireValid & mie_q[11] & mip_q[11];
    assign pend_sw  = mstatus_mie & retireValid & mie_q[3]  & mip_q[3];
    assign pend_tmr = mstatus_mie & retireValid & mie_q[7]  & mip_q[7];
    assign any_irq  = pend_ext | pend_sw | pend_tmr;

    // Fixed priority: external, then software, then timer.
    always_comb begin
        irq_code = 4'd7;
        if (pend_ext) begin
            irq_code = 4'd11;
        end else if (pend_sw) begin
            irq_code = 4'd3;
        end
    end

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie;
        mstatus_rd[3]     = mstatus_mie;
    end

    // Evaluated in COMMIT, so it sees any MTVEC write made in the take cycle.
    always_comb begin
        trap_target = mtvec_q & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
        if (mtvec_q[0] && pend_intr) begin
            trap_target = trap_target + XLEN'({pend_code, 2'b00});
        end
`endif
    end

    always_comb begin
        csrHit      = 1'b1;
        csrReadData = '0;
        case (csrAddress)
            ADDR_MSTATUS:  csrReadData = mstatus_rd;
            ADDR_MIE:      csrReadData = mie_q;
            ADDR_MTVEC:    csrReadData = mtvec_q;
            ADDR_MSCRATCH: csrReadData = mscratch_q;
            ADDR_MEPC:     csrReadData = mepc_q;
            ADDR_MCAUSE:   csrReadData = mcause_q;
            ADDR_MTVAL:    csrReadData = mtval_q;
            ADDR_MIP:      csrReadData = mip_q;
            default:       csrHit      = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            flush         <= 1'b0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
            busy          <= 1'b0;
            mstatus_mie   <= 1'b0;
            mstatus_mpie  <= 1'b0;
            mie_q         <= '0;
            mip_q         <= '0;
            mtvec_q       <= MTVEC_RESET & MTVEC_MASK;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            pend_mret     <= 1'b0;
            pend_intr     <= 1'b0;
            pend_code     <= '0;
            pend_epc      <= '0;
            pend_tval     <= '0;
        end else begin
            mip_q <= irq_word;

            case (state)
                ST_IDLE: begin
                    if (csrWriteEnable) begin
                        case (csrAddress)
                            ADDR_MSTATUS: begin
                                mstatus_mie  <= csrWriteData[3];
                                mstatus_mpie <= csrWriteData[7];
                            end
                            ADDR_MIE:      mie_q      <= csrWriteData & IRQ_MASK;
                            ADDR_MTVEC:    mtvec_q    <= csrWriteData & MTVEC_MASK;
                            ADDR_MSCRATCH: mscratch_q <= csrWriteData;
                            ADDR_MEPC:     mepc_q     <= csrWriteData & EPC_MASK;
                            ADDR_MCAUSE:   mcause_q   <= csrWriteData;
                            ADDR_MTVAL:    mtval_q    <= csrWriteData;
                            default: ;
                        endcase
                    end

                    if (exceptionValid || mretValid || any_irq) begin
                        state     <= ST_FLUSH;
                        flush     <= 1'b1;
                        busy      <= 1'b1;
                        pend_mret <= !exceptionValid && mretValid;
                        pend_intr <= !exceptionValid && !mretValid;
                        pend_code <= exceptionValid ? exceptionCause : irq_code;
                        pend_epc  <= exceptionValid ? exceptionPc : nextPc;
                        pend_tval <= exceptionValid ? exceptionTval : '0;
                    end
                end

                ST_FLUSH: begin
                    flush <= 1'b0;
                    state <= ST_COMMIT;
                end

                ST_COMMIT: begin
                    if (pend_mret) begin
                        mstatus_mie  <= mstatus_mpie;
                        mstatus_mpie <= 1'b1;
                        redirectPc   <= mepc_q;
                    end else begin
                        mepc_q       <= pend_epc & EPC_MASK;
                        mcause_q     <= {pend_intr, {(XLEN-5){1'b0}}, pend_code};
                        mtval_q      <= pend_tval;
                        mstatus_mpie <= mstatus_mie;
                        mstatus_mie  <= 1'b0;
                        redirectPc   <= trap_target;
                    end
                    redirectValid <= 1'b1;
                    state         <= ST_REDIRECT;
                end

                ST_REDIRECT: begin
                    redirectValid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - self-checking bench for trap_controller
module tb_trap_controller;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0400;
`ifdef TRAP_VECTORED_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        exceptionValid;
    logic [3:0]  exceptionCause;
    logic [31:0] exceptionPc;
    logic [31:0] exceptionTval;
    logic        mretValid;
    logic        retireValid;
    logic [31:0] nextPc;
    logic        irqSoftware;
    logic        irqTimer;
    logic        irqExternal;
    logic [11:0] csrAddress;
    logic        csrWriteEnable;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadData;
    logic        csrHit;
    logic        busy;
    logic        flush;
    logic        redirectValid;
    logic [31:0] redirectPc;

    trap_controller #(.XLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
        .clock(clock), .reset(reset),
        .exceptionValid(exceptionValid), .exceptionCause(exceptionCause),
        .exceptionPc(exceptionPc), .exceptionTval(exceptionTval),
        .mretValid(mretValid), .retireValid(retireValid), .nextPc(nextPc),
        .irqSoftware(irqSoftware), .irqTimer(irqTimer), .irqExternal(irqExternal),
        .csrAddress(csrAddress), .csrWriteEnable(csrWriteEnable), .csrWriteData(csrWriteData),
        .csrReadData(csrReadData), .csrHit(csrHit), .busy(busy), .flush(flush),
        .redirectValid(redirectValid), .redirectPc(redirectPc)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_redirect;
    logic [11:0] csr_list [9];

    // Reference model: CSRs as plain words
    bit          m_mie, m_mpie;
    logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        hit;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_ie = 0; m_tvec = MTVEC_RST; m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
    endtask

    function automatic logic [31:0] mip_word();
        return {20'b0, irqExternal, 3'b0, irqTimer, 3'b0, irqSoftware, 3'b0};
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return mip_word();
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h304: m_ie = d & 32'h0000_0888;
            12'h305: m_tvec = d & (VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC);
            12'h340: m_scratch = d;
            12'h341: m_epc = d & 32'hFFFF_FFFC;
            12'h342: m_cause = d;
            12'h343: m_tval = d;
            default: ;
        endcase
    endtask

    task automatic quiet();
        exceptionValid = 0; mretValid = 0; retireValid = 0; csrWriteEnable = 0;
    endtask

    // Random activity while busy; all of it must be ignored.
    task automatic garbage();
        exceptionValid = 1'($urandom_range(0, 1));
        mretValid      = 1'($urandom_range(0, 1));
        retireValid    = 1'($urandom_range(0, 1));
        csrWriteEnable = 1'b1;
        csrAddress     = csr_list[$urandom_range(0, 8)];
        csrWriteData   = $urandom;
        exceptionCause = 4'($urandom_range(0, 11));
        exceptionPc    = $urandom;
        nextPc         = $urandom;
    endtask

    task automatic verify_csrs(input string tag);
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            csrAddress = csr_list[i];
            #1;
            check($sformatf("%s rd %h", tag, csr_list[i]), csrReadData, model_read(csr_list[i]));
            check($sformatf("%s hit %h", tag, csr_list[i]), 32'(csrHit), (i < 8) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clock);
        csrAddress = a;
        #1;
        d = csrReadData;
    endtask

    task automatic run_event(input bit exc, input bit mret, input bit retire, input bit wr,
                             input logic [11:0] waddr, input logic [31:0] wdata,
                             input logic [3:0] ecause, input logic [31:0] epc,
                             input logic [31:0] tval, input logic [31:0] npc, input string tag);
        bit          taken, is_mret, intr;
        logic [3:0]  code;
        logic [31:0] target, pend;
        taken = 0; is_mret = 0; intr = 0; code = 0; target = 0;
        if (exc) begin
            taken = 1; code = ecause;
        end else if (mret) begin
            taken = 1; is_mret = 1;
        end else if (retire && m_mie) begin
            pend = m_ie & mip_word();
            if (pend[11]) code = 11;
            else if (pend[3]) code = 3;
            else if (pend[7]) code = 7;
            taken = (pend != 0);
            intr = taken;
        end
        if (wr) model_write(waddr, wdata);
        if (is_mret) begin
            m_mie = m_mpie; m_mpie = 1; target = m_epc;
        end else if (taken) begin
            m_epc   = (intr ? npc : epc) & 32'hFFFF_FFFC;
            m_cause = {intr, 27'b0, code};
            m_tval  = intr ? 32'h0 : tval;
            m_mpie  = m_mie; m_mie = 0;
            target  = m_tvec & 32'hFFFF_FFFC;
            if (m_tvec[0] && intr) target = target + 4 * 32'(code);
        end

        @(negedge clock);
        exceptionValid = exc; mretValid = mret; retireValid = retire;
        csrWriteEnable = wr; csrAddress = waddr; csrWriteData = wdata;
        exceptionCause = ecause; exceptionPc = epc; exceptionTval = tval; nextPc = npc;
        @(negedge clock);
        check({tag, " flush T+1"}, 32'(flush), 32'(taken));
        check({tag, " busy T+1"}, 32'(busy), 32'(taken));
        check({tag, " rv T+1"}, 32'(redirectValid), 32'd0);
        if (taken) begin
            garbage();
            @(negedge clock);
            check({tag, " flush T+2"}, 32'(flush), 32'd0);
            check({tag, " rv T+2"}, 32'(redirectValid), 32'd0);
            garbage();
            @(negedge clock);
            check({tag, " rv T+3"}, 32'(redirectValid), 32'd1);
            check({tag, " rpc T+3"}, redirectPc, target);
            check({tag, " busy T+3"}, 32'(busy), 32'd1);
            last_redirect = redirectPc;
            garbage();
            @(negedge clock);
            check({tag, " busy T+4"}, 32'(busy), 32'd0);
            check({tag, " rv T+4"}, 32'(redirectValid), 32'd0);
        end
        quiet();
        verify_csrs(tag);
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        run_event(0, 0, 0, 1, a, d, 4'd0, 32'h0, 32'h0, 32'h0, "wr");
    endtask

    initial begin
        logic [31:0] d;
        int          op;
        bit          w;
        logic [11:0] wa;

        csr_list = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
        vecs[0]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b1};
        vecs[1]  = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0888, 1'b1};
        vecs[2]  = '{12'h305, 32'hFFFF_FFFF, VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC, 1'b1};
        vecs[3]  = '{12'h340, 32'h1234_5678, 32'h1234_5678, 1'b1};
        vecs[4]  = '{12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1};
        vecs[5]  = '{12'h342, 32'h8000_000B, 32'h8000_000B, 1'b1};
        vecs[6]  = '{12'h343, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[9]  = '{12'h300, 32'h0000_0000, 32'h0000_1800, 1'b1};
        vecs[10] = '{12'h304, 32'h0000_0000, 32'h0000_0000, 1'b1};

        reset = 1; quiet();
        irqSoftware = 0; irqTimer = 0; irqExternal = 0;
        csrAddress = 0; csrWriteData = 0; exceptionCause = 0;
        exceptionPc = 0; exceptionTval = 0; nextPc = 0; last_redirect = 0;
        repeat (3) @(negedge clock);
        check("reset busy", 32'(busy), 32'd0);
        check("reset flush", 32'(flush), 32'd0);
        check("reset rv", 32'(redirectValid), 32'd0);
        check("reset rpc", redirectPc, 32'd0);
        reset = 0;
        model_reset();
        verify_csrs("reset");

        // CSR write masks, table driven
        for (int i = 0; i < 11; i++) begin
            wr_csr(vecs[i].addr, vecs[i].wdata);
            @(negedge clock);
            csrAddress = vecs[i].addr;
            #1;
            check($sformatf("vec%0d data", i), csrReadData, vecs[i].exp);
            check($sformatf("vec%0d hit", i), 32'(csrHit), 32'(vecs[i].hit));
        end

        // Synchronous exception
        wr_csr(12'h305, 32'h100);
        wr_csr(12'h300, 32'h8);
        run_event(1, 0, 0, 0, 12'h0, 32'h0, 4'd2, 32'h40, 32'hDEAD, 32'h0, "exc");
        check("exc target", last_redirect, 32'h100);
        rd(12'h341, d); check("exc mepc", d, 32'h40);
        rd(12'h342, d); check("exc mcause", d, 32'h2);
        rd(12'h343, d); check("exc mtval", d, 32'hDEAD);
        rd(12'h300, d); check("exc mstatus", d, 32'h1880);

        // Timer interrupt, vectored when the feature is built in
        wr_csr(12'h305, 32'h201);
        wr_csr(12'h300, 32'h8);
        wr_csr(12'h304, 32'h80);
        irqTimer = 1;
        run_event(0, 0, 1, 0, 12'h0, 32'h0, 4'd0, 32'h0, 32'h0, 32'h88, "tmr");
        check("tmr target", last_redirect, VECTORED ? 32'h21C : 32'h200);
        rd(12'h342, d); check("tmr mcause", d, 32'h8000_0007);
        rd(12'h341, d); check("tmr mepc", d, 32'h88);
        irqTimer = 0;

        // Exception beats MRET in the same cycle
        run_event(1, 1, 0, 0, 12'h0, 32'h0, 4'd5, 32'h1234_5670, 32'h77, 32'h0, "exmr");
        rd(12'h341, d); check("exmr mepc", d, 32'h1234_5670);
        rd(12'h342, d); check("exmr mcause", d, 32'h5);

        // MRET restores MIE, then a held external interrupt re-traps
        wr_csr(12'h300, 32'h8);
        run_event(1, 0, 0, 0, 12'h0, 32'h0, 4'd11, 32'h500, 32'h0, 32'h0, "exc2");
        wr_csr(12'h304, 32'h800);
        irqExternal = 1;
        run_event(0, 1, 0, 0, 12'h0, 32'h0, 4'd0, 32'h0, 32'h0, 32'h0, "mret");
        check("mret target", last_redirect, 32'h500);
        rd(12'h300, d); check("mret mstatus", d, 32'h1888);
        run_event(0, 0, 1, 0, 12'h0, 32'h0, 4'd0, 32'h0, 32'h0, 32'h600, "ext");
        rd(12'h342, d); check("ext mcause", d, 32'h8000_000B);
        check("ext target", last_redirect, VECTORED ? 32'h22C : 32'h200);
        irqExternal = 0;

        // Reset during COMMIT
        @(negedge clock);
        exceptionValid = 1; exceptionCause = 4'd4; exceptionPc = 32'h900; exceptionTval = 32'h5;
        @(negedge clock);
        check("rst flush", 32'(flush), 32'd1);
        quiet();
        @(negedge clock);
        check("rst busy commit", 32'(busy), 32'd1);
        reset = 1;
        @(negedge clock);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rv", 32'(redirectValid), 32'd0);
        check("rst flush0", 32'(flush), 32'd0);
        reset = 0;
        model_reset();
        @(negedge clock);
        check("rst rv2", 32'(redirectValid), 32'd0);
        rd(12'h341, d); check("rst mepc", d, 32'h0);
        rd(12'h342, d); check("rst mcause", d, 32'h0);
        verify_csrs("rst");

        // Randomized against the model
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 3);
            w  = 1'($urandom_range(0, 1));
            wa = csr_list[$urandom_range(0, 8)];
            if (op == 3) begin
                irqSoftware = 1'($urandom_range(0, 1));
                irqTimer    = 1'($urandom_range(0, 1));
                irqExternal = 1'($urandom_range(0, 1));
            end
            run_event(op == 1, (op == 2) || (op == 1 && $urandom_range(0, 1) == 1), op == 3, w,
                      wa, $urandom, 4'($urandom_range(0, 11)), $urandom & 32'hFFFF_FFFC,
                      $urandom, $urandom & 32'hFFFF_FFFC, $sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer for the RV32I core. Arbitrates synchronous exceptions, MRET and the three standard interrupts, and owns the trap CSRs: MSTATUS, MIE, MIP, MTVEC, MSCRATCH, MEPC, MCAUSE, MTVAL.
- Drives the pipeline flush and PC redirect through a fixed multi-cycle sequence.
- Sits beside the CSR unit; the CSR unit forwards accesses to these addresses here.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- MTVEC_RESET, 32'h0000_0000, MTVEC reset value.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- exceptionValid  in  1  pipeline reports an exception this cycle
- exceptionCause  in  4  exception code (0..11)
- exceptionPc  in  32  PC of the faulting instruction
- exceptionTval  in  32  trap value
- mretValid  in  1  MRET reaches commit
- retireValid  in  1  instruction boundary; interrupts may be taken
- nextPc  in  32  PC following the retiring instruction
- irqSoftware, irqTimer, irqExternal  in  1 each  level inputs to MIP bits 3, 7, 11
- csrAddress  in  12  CSR address
- csrWriteEnable  in  1  CSR write strobe
- csrWriteData  in  32  CSR write data (final value, already RMW-resolved)
- csrReadData  out  32  combinational read data
- csrHit  out  1  csrAddress is owned by this block
- busy  out  1  FSM not in IDLE
- flush  out  1  kill all in-flight instructions
- redirectValid  out  1  load redirectPc into fetch
- redirectPc  out  32  redirect target

Behaviour:
- Reset values:
  - flush, redirectValid, busy: 0; redirectPc: 0; state: IDLE.
  - MSTATUS = 32'h0000_1800 (MPP hardwired 2'b11); MIE, MEPC, MCAUSE, MTVAL, MSCRATCH = 0; MTVEC = MTVEC_RESET.
- MIP is read-only. Bits 3, 7, 11 reflect irq inputs registered once; all other bits read 0.
- Writable masks:
  - MSTATUS: bits 3 (MIE) and 7 (MPIE) only.
  - MIE: bits 3, 7, 11.
  - MEPC: bits 1:0 forced 0.
  - MTVEC: bit 1 reads 0.
  - MCAUSE, MTVAL, MSCRATCH: full width.
- csrHit is high for the eight owned addresses, else 0. csrReadData is 0 when csrHit is 0.
- CSR writes take effect next cycle, in IDLE only; writes while busy are dropped.
- Take priority, evaluated in IDLE each cycle: exceptionValid > mretValid > interrupt.
- Interrupt pending = MSTATUS.MIE & MIE[i] & MIP[i] & retireValid. Interrupt priority: 11 > 3 > 7.
- On take, latch:
  - epc: exceptionPc for exceptions, nextPc for interrupts.
  - cause: {interrupt flag, 27'b0, code}.
  - tval: exceptionTval for exceptions, 0 for interrupts.
  - kind: trap or MRET.
- FSM: IDLE -> FLUSH -> COMMIT -> REDIRECT -> IDLE.
  - FLUSH: flush=1 for exactly one cycle.
  - COMMIT, trap: MEPC<=epc, MCAUSE<=cause, MTVAL<=tval, MPIE<=MIE, MIE<=0.
  - COMMIT, MRET: MIE<=MPIE, MPIE<=1.
  - REDIRECT: redirectValid=1 for one cycle.
    - Trap target: MTVEC[31:2]<<2. If MTVEC[0]=1 and the cause is an interrupt, target is base + 4*code.
    - MRET target: MEPC as updated in COMMIT.
- Latency from take to redirectValid is 3 cycles. busy=1 in FLUSH, COMMIT and REDIRECT.
- Event inputs are ignored while busy; the pipeline is flushed, so they are not re-presented.
- A CSR write and a take in the same IDLE cycle: the write applies first; COMMIT overwrites the trap fields.
- Reset asserted in any state returns to IDLE next cycle with all reset values; no partial commit persists.
- Interrupt inputs are level-sensitive. A source still asserted after MRET re-traps at the next retireValid when enabled.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: MTVEC[0] is writable; vectored interrupt targets are base + 4*code.
- Undefined: MTVEC[1:0] hardwired 00; all traps go to base; writes to bit 0 are ignored and read back 0.

Test Plan:
- Reset, then read all owned CSRs -> MSTATUS=32'h1800, MTVEC=MTVEC_RESET, others 0; busy=0.
- MTVEC=32'h100, exceptionValid, cause=2, pc=32'h40, tval=32'hDEAD -> flush at T+1, redirect to 32'h100 at T+3. MEPC=32'h40, MCAUSE=2, MTVAL=32'hDEAD, MIE bit 3 cleared, MPIE set.
- TRAP_VECTORED_EN, MTVEC=32'h201, MSTATUS.MIE=1, MIE[7]=1, irqTimer=1, retireValid, nextPc=32'h88 -> redirect 32'h21C. MCAUSE=32'h8000_0007, MEPC=32'h88.
- exceptionValid and mretValid in the same cycle -> exception taken; MRET ignored; MEPC=exceptionPc.
- After a trap, mretValid -> redirect to MEPC; MSTATUS.MIE restored to 1, MPIE=1. With irqExternal held and MIE[11]=1, the next retireValid re-traps with cause 32'h8000_000B.
- Reset asserted during COMMIT -> IDLE next cycle; MEPC and MCAUSE at reset values; no redirectValid issued.
